histogram_reader: RTL
=====================

Name: histogram_reader

Overview:
- Initiator/consumer on the read side of the histogram engine's readout interface (readHistogram, xHistogramOut, yHistogramOut, xValid, yValid).
- On a start request it pulses readHistogram and captures the X and Y projection streams of the median-filtered binary image.
- Per axis it reduces each stream to a peak bin and the first/last bins at or above a threshold, which together give an object bounding box for the wake-up logic.
- Sits beside the histogram engine in the top level; no bin storage, streaming reduction only.

Parameters:
- NUM_BINS, 256, bins per axis; one bin per image row/column.
- BIN_WIDTH, 9, width of a bin count (0..256).
- IDX_WIDTH, 8, width of a bin index; must satisfy 2^IDX_WIDTH >= NUM_BINS.
- TIMEOUT, 1023, maximum idle cycles between beats while collecting before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startRead  in  1  one-cycle request to read and reduce the histograms.
- binThreshold  in  BIN_WIDTH  occupancy threshold; sampled on accepted startRead.
- readHistogram  out  1  one-cycle read request to the histogram engine.
- xHistogramOut  in  BIN_WIDTH  X bin count; valid when xValid=1.
- yHistogramOut  in  BIN_WIDTH  Y bin count; valid when yValid=1.
- xValid  in  1  X beat strobe; bins arrive in index order 0..NUM_BINS-1.
- yValid  in  1  Y beat strobe; independent of xValid, same ordering.
- busy  out  1  high from accepted startRead until done.
- done  out  1  one-cycle completion pulse.
- timeoutErr  out  1  sticky abort flag; cleared by the next accepted startRead.
- xPeakIdx, yPeakIdx  out  IDX_WIDTH  index of the maximum bin.
- xPeakVal, yPeakVal  out  BIN_WIDTH  value of the maximum bin.
- xMin, xMax, yMin, yMax  out  IDX_WIDTH  first and last bin index with count >= threshold.
- boxValid  out  1  both axes had at least one bin >= threshold.

Behaviour:
- Reset (async, immediate): FSM to IDLE.
  - All outputs 0: readHistogram, busy, done, timeoutErr, boxValid, peaks, bounds.
  - Bin counters, running maxima, seen-flags and timeout counter cleared.
- FSM states: IDLE, REQ, COLLECT, FINISH.
- IDLE: startRead=1 → REQ. On that edge:
  - latch binThreshold;
  - clear timeoutErr, boxValid, bin counters, running max, seen-flags;
  - set busy=1.
  - Result outputs hold their previous values until FINISH.
- REQ: readHistogram=1 for exactly this one cycle → COLLECT. Any beats arriving in REQ are accepted.
- COLLECT, per axis A in {x, y}, on each A-valid beat while count_A < NUM_BINS:
  - Bin index = count_A; count_A increments.
  - Peak: if value > runningMax_A, update max and index. Strict compare, so the first occurrence wins ties. Initial max 0 with index 0, so an all-zero axis reports peak idx 0, val 0.
  - Bounds: if value >= latched threshold:
    - first such beat sets min_A = max_A = index and seen_A = 1;
    - later qualifying beats update max_A only.
  - Beats after count_A reaches NUM_BINS are ignored.
- X and Y beats in the same cycle are both processed.
- Timeout counter:
  - resets to 0 on any accepted beat;
  - otherwise increments each COLLECT cycle;
  - on reaching TIMEOUT: timeoutErr=1, go to FINISH with the partial results.
- Normal exit: when both counts equal NUM_BINS → FINISH. The transition is registered: the cycle after the last beat is accepted.
- FINISH (one cycle), results registered to outputs:
  - peaks;
  - bounds; a bound is 0 if its axis was never seen;
  - boxValid = seen_x & seen_y.
  - done=1 and busy=0 in this same cycle. Next state IDLE.
- startRead while busy: ignored, with no effect on latched threshold or counters.
- Threshold 0: every bin qualifies, giving min=0 and max=NUM_BINS-1 for a completed axis.
- Arithmetic: unsigned compares only; counters IDX_WIDTH+1 bits wide so NUM_BINS is representable.
- Reset mid-COLLECT: immediate abort, no done pulse, all outputs 0.

Test Plan:
1. Reset, then startRead with threshold 3; X = 0 except bins 10..20 = 5; Y = 0 except bins 40..45 = 4 with bin 42 = 9.
   → readHistogram one pulse exactly 1 cycle after start.
   → done; xMin=10, xMax=20, xPeakIdx=10, xPeakVal=5; yMin=40, yMax=45, yPeakIdx=42, yPeakVal=9; boxValid=1; timeoutErr=0.
2. All X bins = 0, Y normal, threshold 1.
   → boxValid=0; xMin=xMax=0; xPeakVal=0.
3. X beats every cycle while Y beats every 3rd cycle, interleaved and simultaneous.
   → done exactly 1 cycle after the 256th Y beat; results identical to the same data delivered back-to-back.
4. Stream stalls after 100 X beats; TIMEOUT=1023.
   → timeoutErr=1 and done after 1023 idle cycles; the next startRead clears timeoutErr.
5. Second startRead mid-COLLECT, plus 5 extra X beats after bin 255.
   → no second readHistogram; extra beats do not alter xMax or xPeak.
6. Assert reset at beat 128.
   → busy, done and all outputs 0 immediately; a fresh run afterwards completes correctly.

Source files
------------

// File: rtl/histogram_reader_if.sv
// Readout link between the histogram engine and its reader: a one-cycle read
// request going out, and two independent X/Y bin streams coming back.
interface histogram_reader_if #(
  parameter int BIN_WIDTH = 9
);
  logic                 readHistogram;
  logic [BIN_WIDTH-1:0] xHistogramOut;
  logic [BIN_WIDTH-1:0] yHistogramOut;
  logic                 xValid;
  logic                 yValid;

  // Reader side: issues the request and consumes both projection streams.
  modport master (
    output readHistogram,
    input  xHistogramOut,
    input  yHistogramOut,
    input  xValid,
    input  yValid
  );

  // Engine side: answers the request with the two streams.
  modport slave (
    input  readHistogram,
    output xHistogramOut,
    output yHistogramOut,
    output xValid,
    output yValid
  );
endinterface

// File: rtl/histogram_reader.sv
// Histogram reader: requests one readout of the X/Y projection histograms and
// reduces each stream on the fly to a peak bin plus the first/last bins at or
// above a threshold, giving an object bounding box. No bin storage is kept.
module histogram_reader #(
  parameter int NUM_BINS  = 256,
  parameter int BIN_WIDTH = 9,
  parameter int IDX_WIDTH = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startRead,
  input  logic [BIN_WIDTH-1:0] binThreshold,
  histogram_reader_if.master   hist,
  output logic                 busy,
  output logic                 done,
  output logic                 timeoutErr,
  output logic [IDX_WIDTH-1:0] xPeakIdx,
  output logic [IDX_WIDTH-1:0] yPeakIdx,
  output logic [BIN_WIDTH-1:0] xPeakVal,
  output logic [BIN_WIDTH-1:0] yPeakVal,
  output logic [IDX_WIDTH-1:0] xMin,
  output logic [IDX_WIDTH-1:0] xMax,
  output logic [IDX_WIDTH-1:0] yMin,
  output logic [IDX_WIDTH-1:0] yMax,
  output logic                 boxValid
);

  localparam int CNT_W = IDX_WIDTH + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BINS    = CNT_W'(NUM_BINS);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, FINISH} state_t;

  state_t state_q, state_d;

  logic [BIN_WIDTH-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]     xCnt_q, xCnt_d, yCnt_q, yCnt_d;
  logic [BIN_WIDTH-1:0] xRunVal_q, xRunVal_d, yRunVal_q, yRunVal_d;
  logic [IDX_WIDTH-1:0] xRunIdx_q, xRunIdx_d, yRunIdx_q, yRunIdx_d;
  logic [IDX_WIDTH-1:0] xLo_q, xLo_d, xHi_q, xHi_d;
  logic [IDX_WIDTH-1:0] yLo_q, yLo_d, yHi_q, yHi_d;
  logic                 xSeen_q, xSeen_d, ySeen_q, ySeen_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 err_q, err_d;
  logic                 box_q, box_d;
  logic [IDX_WIDTH-1:0] xPeakIdx_q, xPeakIdx_d, yPeakIdx_q, yPeakIdx_d;
  logic [BIN_WIDTH-1:0] xPeakVal_q, xPeakVal_d, yPeakVal_q, yPeakVal_d;
  logic [IDX_WIDTH-1:0] xMin_q, xMin_d, xMax_q, xMax_d;
  logic [IDX_WIDTH-1:0] yMin_q, yMin_d, yMax_q, yMax_d;

  logic                 startAccept;
  logic                 collecting;
  logic                 xAccept, yAccept;
  logic                 timeoutHit;
  logic [BIN_WIDTH-1:0] xBeat, yBeat;
  logic [IDX_WIDTH-1:0] xIdx, yIdx;

  assign startAccept = (state_q == IDLE) && startRead;
  assign collecting  = (state_q == REQ) || (state_q == COLLECT);
  assign xBeat       = hist.xHistogramOut;
  assign yBeat       = hist.yHistogramOut;
  assign xIdx        = xCnt_q[IDX_WIDTH-1:0];
  assign yIdx        = yCnt_q[IDX_WIDTH-1:0];
  assign xAccept     = collecting && hist.xValid && (xCnt_q < BINS);
  assign yAccept     = collecting && hist.yValid && (yCnt_q < BINS);

  // Streaming reduction: per-axis bin count, running peak, threshold bounds and the idle-gap counter.
  always_comb begin
    thr_d     = thr_q;
    xCnt_d    = xCnt_q;
    yCnt_d    = yCnt_q;
    xRunVal_d = xRunVal_q;
    yRunVal_d = yRunVal_q;
    xRunIdx_d = xRunIdx_q;
    yRunIdx_d = yRunIdx_q;
    xLo_d     = xLo_q;
    xHi_d     = xHi_q;
    yLo_d     = yLo_q;
    yHi_d     = yHi_q;
    xSeen_d   = xSeen_q;
    ySeen_d   = ySeen_q;
    tmo_d     = tmo_q;

    if (startAccept) begin
      thr_d     = binThreshold;
      xCnt_d    = '0;
      yCnt_d    = '0;
      xRunVal_d = '0;
      yRunVal_d = '0;
      xRunIdx_d = '0;
      yRunIdx_d = '0;
      xLo_d     = '0;
      xHi_d     = '0;
      yLo_d     = '0;
      yHi_d     = '0;
      xSeen_d   = 1'b0;
      ySeen_d   = 1'b0;
      tmo_d     = '0;
    end

    if (xAccept) begin
      if (xBeat > xRunVal_q) begin
        xRunVal_d = xBeat;
        xRunIdx_d = xIdx;
      end
      if (xBeat >= thr_q) begin
        if (!xSeen_q) begin
          xLo_d   = xIdx;
          xSeen_d = 1'b1;
        end
        xHi_d = xIdx;
      end
      xCnt_d = xCnt_q + CNT_W'(1);
    end

    if (yAccept) begin
      if (yBeat > yRunVal_q) begin
        yRunVal_d = yBeat;
        yRunIdx_d = yIdx;
      end
      if (yBeat >= thr_q) begin
        if (!ySeen_q) begin
          yLo_d   = yIdx;
          ySeen_d = 1'b1;
        end
        yHi_d = yIdx;
      end
      yCnt_d = yCnt_q + CNT_W'(1);
    end

    if (state_q == COLLECT) begin
      tmo_d = (xAccept || yAccept) ? '0 : tmo_q + TMO_W'(1);
    end
  end

  // Next state: leave COLLECT as soon as the final beat lands or the idle gap runs out.
  always_comb begin
    state_d    = state_q;
    timeoutHit = 1'b0;
    case (state_q)
      IDLE:    if (startRead) state_d = REQ;
      REQ:     state_d = COLLECT;
      COLLECT: begin
        if ((xCnt_d == BINS) && (yCnt_d == BINS)) begin
          state_d = FINISH;
        end else if (tmo_d == TMO_MAX) begin
          state_d    = FINISH;
          timeoutHit = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers: hold the previous run until the edge into FINISH, then load the reduction.
  always_comb begin
    err_d      = err_q;
    box_d      = box_q;
    xPeakIdx_d = xPeakIdx_q;
    yPeakIdx_d = yPeakIdx_q;
    xPeakVal_d = xPeakVal_q;
    yPeakVal_d = yPeakVal_q;
    xMin_d     = xMin_q;
    xMax_d     = xMax_q;
    yMin_d     = yMin_q;
    yMax_d     = yMax_q;

    if (startAccept) begin
      err_d = 1'b0;
      box_d = 1'b0;
    end
    if (timeoutHit) begin
      err_d = 1'b1;
    end
    if ((state_q == COLLECT) && (state_d == FINISH)) begin
      xPeakIdx_d = xRunIdx_d;
      yPeakIdx_d = yRunIdx_d;
      xPeakVal_d = xRunVal_d;
      yPeakVal_d = yRunVal_d;
      xMin_d     = xSeen_d ? xLo_d : '0;
      xMax_d     = xSeen_d ? xHi_d : '0;
      yMin_d     = ySeen_d ? yLo_d : '0;
      yMax_d     = ySeen_d ? yHi_d : '0;
      box_d      = xSeen_d && ySeen_d;
    end
  end

  // State, reduction and result registers; reset aborts any run and zeroes every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      xRunVal_q  <= '0;
      yRunVal_q  <= '0;
      xRunIdx_q  <= '0;
      yRunIdx_q  <= '0;
      xLo_q      <= '0;
      xHi_q      <= '0;
      yLo_q      <= '0;
      yHi_q      <= '0;
      xSeen_q    <= 1'b0;
      ySeen_q    <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      box_q      <= 1'b0;
      xPeakIdx_q <= '0;
      yPeakIdx_q <= '0;
      xPeakVal_q <= '0;
      yPeakVal_q <= '0;
      xMin_q     <= '0;
      xMax_q     <= '0;
      yMin_q     <= '0;
      yMax_q     <= '0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      xRunVal_q  <= xRunVal_d;
      yRunVal_q  <= yRunVal_d;
      xRunIdx_q  <= xRunIdx_d;
      yRunIdx_q  <= yRunIdx_d;
      xLo_q      <= xLo_d;
      xHi_q      <= xHi_d;
      yLo_q      <= yLo_d;
      yHi_q      <= yHi_d;
      xSeen_q    <= xSeen_d;
      ySeen_q    <= ySeen_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      box_q      <= box_d;
      xPeakIdx_q <= xPeakIdx_d;
      yPeakIdx_q <= yPeakIdx_d;
      xPeakVal_q <= xPeakVal_d;
      yPeakVal_q <= yPeakVal_d;
      xMin_q     <= xMin_d;
      xMax_q     <= xMax_d;
      yMin_q     <= yMin_d;
      yMax_q     <= yMax_d;
    end
  end

  assign hist.readHistogram = (state_q == REQ);
  assign busy       = collecting;
  assign done       = (state_q == FINISH);
  assign timeoutErr = err_q;
  assign boxValid   = box_q;
  assign xPeakIdx   = xPeakIdx_q;
  assign yPeakIdx   = yPeakIdx_q;
  assign xPeakVal   = xPeakVal_q;
  assign yPeakVal   = yPeakVal_q;
  assign xMin       = xMin_q;
  assign xMax       = xMax_q;
  assign yMin       = yMin_q;
  assign yMax       = yMax_q;

endmodule
